// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencer with one outstanding imem request
// and a small prefetch queue feeding the decoder.
module fetch_unit #(
  parameter int AW    = 16,
  parameter int IW    = 16,
  parameter int OFFW  = 6,
  parameter int DEPTH = 2,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RESET,
  output logic            imem_req,
  output logic [AW-1:0]   imem_addr,
  input  logic            imem_ack,
  input  logic [IW-1:0]   imem_data,
  output logic            inst_valid,
  output logic [IW-1:0]   inst,
  output logic [AW-1:0]   inst_pc,
  input  logic            inst_ready,
  input  logic            br_valid,
  input  logic            br_mode,
  input  logic [AW-1:0]   br_target,
  input  logic [AW-1:0]   br_pc,
  input  logic [OFFW-1:0] br_offset
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [AW-1:0] A_ONE = AW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [AW-1:0] fpc;
  logic [AW-1:0] fpc_n;
  logic [AW-1:0] areq;
  logic [AW-1:0] areq_n;
  logic [AW-1:0] off_sx;
  logic [AW-1:0] target;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] count_n;

  logic [AW-1:0] q_pc   [DEPTH];
  logic [IW-1:0] q_inst [DEPTH];

  logic xfer;
  logic push;
  logic pop;

  assign off_sx = {{(AW-OFFW){br_offset[OFFW-1]}}, br_offset};
  assign target = br_mode ? (br_pc + off_sx) : br_target;

  assign imem_req   = (state != S_IDLE);
  assign imem_addr  = areq;
  assign inst_valid = (count != '0);
  assign inst       = q_inst[head];
  assign inst_pc    = q_pc[head];

  assign xfer = imem_req & imem_ack;
  assign pop  = inst_valid & inst_ready;
  // stale data in DROP and data racing a redirect are never queued
  assign push = (state == S_REQ) & xfer & ~br_valid;

  always_comb begin
    count_n = count;
    if (br_valid)
      count_n = '0;
    else if (push & ~pop)
      count_n = count + C_ONE;
    else if (pop & ~push)
      count_n = count - C_ONE;
  end

  always_comb begin
    state_n = state;
    fpc_n   = fpc;
    areq_n  = areq;
    unique case (state)
      S_IDLE: begin
        if (br_valid) begin
          fpc_n   = target;
          areq_n  = target;
          state_n = S_REQ;
        end else if (count < FULL) begin
          areq_n  = fpc;
          state_n = S_REQ;
        end
      end
      S_REQ: begin
        if (br_valid) begin
          fpc_n = target;
          if (xfer)
            areq_n = target;
          else
            state_n = S_DROP;
        end else if (xfer) begin
          fpc_n = fpc + A_ONE;
          if (count_n < FULL)
            areq_n = fpc + A_ONE;
          else
            state_n = S_IDLE;
        end
      end
      S_DROP: begin
        if (br_valid) begin
          fpc_n = target;
        end else if (xfer) begin
          areq_n  = fpc;
          state_n = S_REQ;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= S_IDLE;
      fpc   <= RESET_PC;
      areq  <= RESET_PC;
      count <= '0;
    end else begin
      state <= state_n;
      fpc   <= fpc_n;
      areq  <= areq_n;
      count <= count_n;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]   <= '0;
        q_inst[i] <= '0;
      end
    end else if (br_valid) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (pop)
        head <= head + P_ONE;
      if (push) begin
        q_pc[tail]   <= areq;
        q_inst[tail] <= imem_data;
        tail         <= tail + P_ONE;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench; a wait-state memory model feeds
// the DUT and every popped instruction is checked in order.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = '0;
  logic        inst_ready = 1'b0;
  logic        br_valid = 1'b0;
  logic        br_mode = 1'b0;
  logic [15:0] br_target = '0;
  logic [15:0] br_pc = '0;
  logic [5:0]  br_offset = '0;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;

  logic        w_req;
  logic [15:0] w_addr;
  logic        w_valid;
  logic [15:0] w_inst;
  logic [15:0] w_pc;

  int nvec = 0;
  int nerr = 0;
  int wait_n = 0;
  int wcnt = 0;
  int npops = 0;

  logic [15:0] exp_q [$];
  logic [15:0] exp_tgt = '0;
  logic [15:0] stale;
  logic [15:0] e;
  logic        found;

  always #5 CLK = ~CLK;

  fetch_unit dut (
    .CLK(CLK), .RESET(RESET),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .inst_ready(inst_ready),
    .br_valid(br_valid), .br_mode(br_mode),
    .br_target(br_target), .br_pc(br_pc),
    .br_offset(br_offset)
  );

  fetch_unit #(.RESET_PC(16'hFFFE)) dut_w (
    .CLK(CLK), .RESET(RESET),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .inst_valid(w_valid), .inst(w_inst),
    .inst_pc(w_pc), .inst_ready(inst_ready),
    .br_valid(br_valid), .br_mode(br_mode),
    .br_target(br_target), .br_pc(br_pc),
    .br_offset(br_offset)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // memory: ack after wait_n idle cycles of a request
  always @(negedge CLK) begin
    if (imem_req && wcnt >= wait_n) begin
      imem_ack  = 1'b1;
      imem_data = imem_addr ^ 16'hA5A5;
      wcnt      = 0;
    end else begin
      imem_ack = 1'b0;
      if (imem_req) wcnt++;
      else wcnt = 0;
    end
  end

  // scoreboard: check pops, then reload on redirect
  always @(negedge CLK) begin
    if (RESET) begin
      chk("q_ovf",
          32'(dut.push && dut.count == 2'd2), 32'd0);
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_under", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("pop_pc", 32'(inst_pc), 32'(e));
          chk("pop_inst", 32'(inst),
              32'(e ^ 16'hA5A5));
          npops++;
        end
      end
      if (br_valid) begin
        exp_q.delete();
        for (int i = 0; i < 64; i++)
          exp_q.push_back(exp_tgt + 16'(i));
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    RESET = 1'b0;
    br_valid = 1'b0;
    inst_ready = rdy;
    wait_n = 0;
    step();
    step();
    exp_q.delete();
    for (int i = 0; i < 64; i++)
      exp_q.push_back(16'(i));
    RESET = 1'b1;
  endtask

  task automatic do_branch(input logic m,
                           input logic [15:0] tgt,
                           input logic [15:0] pc,
                           input logic [5:0] off,
                           input logic [15:0] exp);
    br_valid  = 1'b1;
    br_mode   = m;
    br_target = tgt;
    br_pc     = pc;
    br_offset = off;
    exp_tgt   = exp;
    step();
    br_valid = 1'b0;
    chk("br_valid0", 32'(inst_valid), 32'd0);
    chk("br_addr", 32'(imem_addr), 32'(exp));
    chk("br_req", 32'(imem_req), 32'd1);
    inst_ready = 1'b1;
    step();
    chk("br_v", 32'(inst_valid), 32'd1);
    chk("br_pc", 32'(inst_pc), 32'(exp));
    step();
    step();
  endtask

  initial begin
    #2 RESET = 1'b0;
    #2;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", 32'(inst), 32'd0);
    chk("rst_pc", 32'(inst_pc), 32'd0);
    chk("rst_waddr", 32'(w_addr), 32'hFFFE);

    // startup streaming
    do_reset(1'b1);
    step();
    chk("c1_req", 32'(imem_req), 32'd1);
    chk("c1_addr", 32'(imem_addr), 32'd0);
    chk("c1_valid", 32'(inst_valid), 32'd0);
    chk("w_c1", 32'(w_addr), 32'hFFFE);
    step();
    chk("c2_addr", 32'(imem_addr), 32'd1);
    chk("c2_valid", 32'(inst_valid), 32'd1);
    chk("c2_pc", 32'(inst_pc), 32'd0);
    chk("w_c2", 32'(w_addr), 32'hFFFF);
    step();
    chk("w_c3", 32'(w_addr), 32'h0000);
    for (int k = 3; k < 10; k++) begin
      chk("seq_addr", 32'(imem_addr), 32'(k - 1));
      chk("seq_valid", 32'(inst_valid), 32'd1);
      step();
    end

    // backpressure
    do_reset(1'b0);
    step();
    step();
    step();
    chk("bp_req3", 32'(imem_req), 32'd0);
    chk("bp_valid", 32'(inst_valid), 32'd1);
    chk("bp_pc", 32'(inst_pc), 32'd0);
    step();
    chk("bp_req4", 32'(imem_req), 32'd0);
    npops = 0;
    inst_ready = 1'b1;
    for (int k = 0; k < 10; k++) step();
    chk("bp_pops", 32'(npops >= 4), 32'd1);

    // absolute jump with a full queue
    do_reset(1'b0);
    for (int k = 0; k < 4; k++) step();
    chk("jmp_full", 32'(dut.count), 32'd2);
    do_branch(1'b0, 16'h0040, 16'h0, 6'h0, 16'h0040);

    // relative branches while streaming
    do_branch(1'b1, 16'h0, 16'h0010, 6'b111110, 16'h000E);
    do_branch(1'b1, 16'h0, 16'h0010, 6'h1F, 16'h002F);
    do_branch(1'b1, 16'h0, 16'hFFFF, 6'h01, 16'h0000);

    // redirect during a 3-cycle memory wait
    wait_n = 3;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (wcnt == 1) found = 1'b1;
    end
    chk("drop_sync", 32'(found), 32'd1);
    stale = imem_addr;
    br_valid = 1'b1;
    br_mode = 1'b0;
    br_target = 16'h0100;
    exp_tgt = 16'h0100;
    step();
    br_valid = 1'b0;
    chk("drop_a1", 32'(imem_addr), 32'(stale));
    chk("drop_req", 32'(imem_req), 32'd1);
    chk("drop_v", 32'(inst_valid), 32'd0);
    step();
    chk("drop_a2", 32'(imem_addr), 32'(stale));
    step();
    chk("drop_tgt", 32'(imem_addr), 32'h0100);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (inst_valid) found = 1'b1;
    end
    chk("drop_wait", 32'(found), 32'd1);
    chk("drop_pc", 32'(inst_pc), 32'h0100);
    wait_n = 0;
    for (int k = 0; k < 8; k++) step();

    // reset mid-request
    chk("pre_req", 32'(imem_req), 32'd1);
    #2 RESET = 1'b0;
    #1;
    chk("mid_req", 32'(imem_req), 32'd0);
    chk("mid_valid", 32'(inst_valid), 32'd0);
    chk("mid_addr", 32'(imem_addr), 32'd0);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
